// File: rtl/branch_predict_ctrl_pkg.sv
// branch_predict_ctrl_pkg: shared encodings for the front-end branch predictor.
package branch_predict_ctrl_pkg;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} bht_e;
  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} fsm_e;
  localparam logic [4:0] LINK_RA = 5'd1;
  localparam logic [4:0] LINK_T0 = 5'd5;
  function automatic logic is_link(input logic [4:0] r);
    return r == LINK_RA || r == LINK_T0;
  endfunction
endpackage

// File: rtl/branch_predict_ctrl_ras_stack.sv
// branch_predict_ctrl_ras_stack: circular return-address stack; a full push overwrites the oldest entry.
module branch_predict_ctrl_ras_stack #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic [31:0] i_data,
  output logic [31:0] o_top,
  output logic        o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0]   r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] w_top_idx;
  logic          w_do_pop;
  assign w_top_idx = r_ptr - PW'(1);
  assign o_empty   = r_cnt == '0;
  assign o_top     = r_mem[w_top_idx];
  assign w_do_pop  = i_pop && !o_empty;
  // pop-then-push collapses to replacing the top entry in place
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_pop && i_push) begin
      r_mem[w_top_idx] <= i_data;
    end else if (w_do_pop) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - CW'(1);
    end else if (i_push) begin
      r_mem[r_ptr] <= i_data;
      r_ptr        <= r_ptr + PW'(1);
      if (r_cnt != CW'(DEPTH)) r_cnt <= r_cnt + CW'(1);
    end
endmodule

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: BHT/RAS next-PC prediction with registered redirect and timed flush on mispredict.
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int BHT_IDX_W    = 6,
  parameter int RAS_DEPTH    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic        if_stall,
  input  logic [31:0] if_pc,
  input  logic        if_B_type,
  input  logic        if_jal,
  input  logic        if_jalr,
  input  logic [4:0]  if_rs1,
  input  logic [4:0]  if_rd,
  input  logic [31:0] if_imme,
  output logic        pred_taken,
  output logic [31:0] pred_pc,
  input  logic        ex_valid,
  input  logic        ex_B_type,
  input  logic        ex_jump,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_pc,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [31:0] mispredict_cnt
);
  localparam int CW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  logic [1:0]           r_bht [2**BHT_IDX_W];
  fsm_e                 r_state;
  logic [CW-1:0]        r_fcnt;
  logic                 r_redirect, r_flush;
  logic [31:0]          r_redirect_pc, r_cnt;
  logic [BHT_IDX_W-1:0] w_if_idx, w_ex_idx;
  logic [1:0]           w_ex_bht;
  logic                 w_if_upd, w_pop, w_push, w_ras_empty, w_ex_op, w_mispredict;
  logic [31:0]          w_ras_top, w_seq_pc, w_br_pc, w_correct_pc;
  assign w_if_idx = if_pc[BHT_IDX_W+1:2];
  assign w_ex_idx = ex_pc[BHT_IDX_W+1:2];
  assign w_ex_bht = r_bht[w_ex_idx];
  assign w_seq_pc = if_pc + 32'd4;
  assign w_br_pc  = if_pc + if_imme;
  assign w_if_upd = if_valid && !if_stall && !r_flush;
  assign w_pop    = if_jalr && is_link(if_rs1) && (if_rd == 5'd0 || (is_link(if_rd) && if_rs1 != if_rd));
  assign w_push   = (if_jal || if_jalr) && is_link(if_rd);
  branch_predict_ctrl_ras_stack #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_if_upd && w_push),
    .i_pop   (w_if_upd && w_pop),
    .i_data  (w_seq_pc),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty)
  );
  assign pred_taken = if_jal ? 1'b1 : if_B_type ? r_bht[w_if_idx][1] : (w_pop && !w_ras_empty);
  assign pred_pc    = !pred_taken ? w_seq_pc : (if_jal || if_B_type) ? w_br_pc : w_ras_top;
  // EX ops arriving during a flush are wrong-path and must not train or redirect
  assign w_ex_op      = ex_valid && (ex_B_type || ex_jump) && r_state == IDLE;
  assign w_mispredict = w_ex_op && ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_pc));
  assign w_correct_pc = ex_taken ? ex_target : ex_pc + 32'd4;
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < 2**BHT_IDX_W; i++) r_bht[i] <= WNT;
    else if (w_ex_op && ex_B_type)
      r_bht[w_ex_idx] <= ex_taken ? (w_ex_bht == ST ? ST : w_ex_bht + 2'd1)
                                  : (w_ex_bht == SNT ? SNT : w_ex_bht - 2'd1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state       <= IDLE;
      r_fcnt        <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_flush       <= 1'b0;
      r_cnt         <= '0;
    end else if (r_state == IDLE) begin
      r_redirect <= w_mispredict;
      if (w_mispredict) begin
        r_state       <= FLUSH;
        r_fcnt        <= CW'(FLUSH_CYCLES - 1);
        r_redirect_pc <= w_correct_pc;
        r_flush       <= 1'b1;
        if (r_cnt != '1) r_cnt <= r_cnt + 32'd1;
      end
    end else begin
      r_redirect <= 1'b0;
      if (r_fcnt == '0) begin
        r_state <= IDLE;
        r_flush <= 1'b0;
      end else begin
        r_fcnt <= r_fcnt - CW'(1);
      end
    end
  assign redirect       = r_redirect;
  assign redirect_pc    = r_redirect_pc;
  assign flush          = r_flush;
  assign mispredict_cnt = r_cnt;
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb_branch_predict_ctrl: scoreboard bench with a queue/array reference model of the predictor.
module tb_branch_predict_ctrl;
  localparam int FC = 2;
  localparam int NB = 64;
  logic clk = 0, rst = 1;
  logic if_valid, if_stall, if_B_type, if_jal, if_jalr;
  logic [31:0] if_pc, if_imme, ex_pc, ex_target, ex_pred_pc;
  logic [4:0] if_rs1, if_rd;
  logic pred_taken, ex_valid, ex_B_type, ex_jump, ex_taken, ex_pred_taken;
  logic [31:0] pred_pc, redirect_pc, mispredict_cnt;
  logic redirect, flush;
  always #5 clk = ~clk;
  branch_predict_ctrl #(.BHT_IDX_W(6), .RAS_DEPTH(4), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_stall(if_stall), .if_pc(if_pc),
    .if_B_type(if_B_type), .if_jal(if_jal), .if_jalr(if_jalr), .if_rs1(if_rs1), .if_rd(if_rd),
    .if_imme(if_imme), .pred_taken(pred_taken), .pred_pc(pred_pc), .ex_valid(ex_valid),
    .ex_B_type(ex_B_type), .ex_jump(ex_jump), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_pc(ex_pred_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .mispredict_cnt(mispredict_cnt)
  );
  typedef struct {logic pt; logic [31:0] ppc; logic fl; logic [31:0] cnt;} exp_t;
  exp_t cq[$];
  logic [31:0] rq[$];
  int compared = 0, mismatched = 0, rd_seen = 0;
  int bht[NB];
  logic [31:0] ras[$];
  int fl_left;
  logic [31:0] m_cnt;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    compared++;
    if (a !== x) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask
  function automatic logic lnk(input logic [4:0] r);
    return r == 5'd1 || r == 5'd5;
  endfunction
  function automatic logic m_pop();
    return if_jalr && lnk(if_rs1) && (if_rd == 5'd0 || (lnk(if_rd) && if_rs1 != if_rd));
  endfunction
  task automatic model_reset();
    foreach (bht[i]) bht[i] = 1;
    ras.delete();
    fl_left = 0;
    m_cnt = 0;
  endtask
  task automatic model_pred(output logic t, output logic [31:0] p);
    int idx = int'((if_pc >> 2) & 32'(NB - 1));
    if (if_jal) begin t = 1; p = if_pc + if_imme; end
    else if (if_B_type) begin t = bht[idx] >= 2; p = t ? if_pc + if_imme : if_pc + 4; end
    else if (m_pop() && ras.size() > 0) begin t = 1; p = ras[$]; end
    else begin t = 0; p = if_pc + 4; end
  endtask
  task automatic model_edge();
    logic acc, mis;
    int ei = int'((ex_pc >> 2) & 32'(NB - 1));
    acc = ex_valid && (ex_B_type || ex_jump) && fl_left == 0;
    mis = acc && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_pc));
    if (acc && ex_B_type) bht[ei] = ex_taken ? (bht[ei] < 3 ? bht[ei] + 1 : 3) : (bht[ei] > 0 ? bht[ei] - 1 : 0);
    if (if_valid && !if_stall && fl_left == 0) begin
      if (m_pop() && ras.size() > 0) void'(ras.pop_back());
      if ((if_jal || if_jalr) && lnk(if_rd)) begin
        ras.push_back(if_pc + 4);
        if (ras.size() > 4) void'(ras.pop_front());
      end
    end
    if (fl_left > 0) fl_left--;
    else if (mis) begin
      fl_left = FC;
      rq.push_back(ex_taken ? ex_target : ex_pc + 4);
      if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
    end
  endtask
  task automatic tick();
    exp_t e;
    logic t;
    logic [31:0] p;
    model_pred(t, p);
    e.pt = t; e.ppc = p; e.fl = fl_left > 0; e.cnt = m_cnt;
    cq.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic clear_in();
    {if_valid, if_stall, if_B_type, if_jal, if_jalr} = '0;
    {if_pc, if_imme, if_rs1, if_rd} = '0;
    {ex_valid, ex_B_type, ex_jump, ex_taken, ex_pred_taken} = '0;
    {ex_pc, ex_target, ex_pred_pc} = '0;
  endtask
  task automatic rand_in();
    logic [4:0] regs [4] = '{5'd0, 5'd1, 5'd5, 5'd2};
    int k = int'($urandom_range(0, 3));
    int j = int'($urandom_range(0, 2));
    if_valid  = $urandom_range(0, 7) != 0;
    if_stall  = $urandom_range(0, 3) == 0;
    if_pc     = 32'h400 + 32'($urandom_range(0, 7)) * 4;
    if_B_type = k == 1;
    if_jal    = k == 2;
    if_jalr   = k == 3;
    if_rs1    = regs[$urandom_range(0, 3)];
    if_rd     = regs[$urandom_range(0, 3)];
    if_imme   = $urandom;
    ex_valid  = $urandom_range(0, 1) == 1;
    ex_B_type = j == 1;
    ex_jump   = j == 2;
    ex_pc     = 32'h400 + 32'($urandom_range(0, 7)) * 4;
    ex_taken  = 1'($urandom);
    ex_target = 32'h800 + 32'($urandom_range(0, 3)) * 4;
    ex_pred_taken = 1'($urandom);
    ex_pred_pc = $urandom_range(0, 1) == 1 ? ex_target : 32'h800 + 32'($urandom_range(0, 3)) * 4;
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (cq.size() > 0) begin
        e = cq.pop_front();
        chk("pred_taken", 32'(pred_taken), 32'(e.pt));
        chk("pred_pc", pred_pc, e.ppc);
        chk("flush", 32'(flush), 32'(e.fl));
        chk("mispredict_cnt", mispredict_cnt, e.cnt);
      end
      if (redirect) begin
        rd_seen++;
        if (rq.size() == 0) chk("unexpected_redirect", 32'(redirect), 32'd0);
        else chk("redirect_pc", redirect_pc, rq.pop_front());
      end
    end
  end
  initial begin
    int r0;
    clear_in();
    model_reset();
    #12 rst = 0;
    @(posedge clk); #1;
    chk("rst_redirect", 32'(redirect), 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_cnt", mispredict_cnt, 0);
    chk("rst_pred_pc", pred_pc, 32'h4);
    if_valid = 1; if_B_type = 1; if_pc = 32'h100; if_imme = 32'h40; #1;
    chk("t1_pred_taken", 32'(pred_taken), 0);
    chk("t1_pred_pc", pred_pc, 32'h104);
    tick();
    clear_in();
    ex_valid = 1; ex_B_type = 1; ex_pc = 32'h100; ex_taken = 1; ex_target = 32'h140; ex_pred_pc = 32'h104;
    tick();
    clear_in(); #1;
    chk("t2_redirect", 32'(redirect), 1);
    chk("t2_redirect_pc", redirect_pc, 32'h140);
    chk("t2_flush", 32'(flush), 1);
    chk("t2_cnt", mispredict_cnt, 1);
    tick();
    chk("t2_redirect_once", 32'(redirect), 0);
    chk("t2_flush_hold", 32'(flush), 1);
    tick();
    chk("t2_flush_drop", 32'(flush), 0);
    if_valid = 1; if_B_type = 1; if_pc = 32'h100; if_imme = 32'h40; #1;
    chk("t2_bht_wt", 32'(pred_taken), 1);
    chk("t2_bht_pc", pred_pc, 32'h140);
    tick();
    clear_in(); if_valid = 1; if_jal = 1; if_rd = 1; if_pc = 32'h200; if_imme = 32'h80; #1;
    chk("t3_jal_taken", 32'(pred_taken), 1);
    chk("t3_jal_pc", pred_pc, 32'h280);
    tick();
    clear_in(); if_valid = 1; if_jalr = 1; if_rs1 = 1; if_pc = 32'h280; #1;
    chk("t3_ret_taken", 32'(pred_taken), 1);
    chk("t3_ret_pc", pred_pc, 32'h204);
    tick();
    for (int i = 0; i < 5; i++) begin
      clear_in(); if_valid = 1; if_jal = 1; if_rd = 5; if_pc = 32'h1000 + 32'(i) * 32'h100; if_imme = 8;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      clear_in(); if_valid = 1; if_jalr = 1; if_rs1 = 5; if_pc = 32'h2000; #1;
      chk("t4_pop_taken", 32'(pred_taken), i < 4 ? 1 : 0);
      chk("t4_pop_pc", pred_pc, i < 4 ? 32'h1004 + 32'(4 - i) * 32'h100 : 32'h2004);
      tick();
    end
    r0 = rd_seen;
    clear_in(); ex_valid = 1; ex_B_type = 1; ex_pc = 32'h304; ex_taken = 1; ex_target = 32'h344; ex_pred_pc = 32'h308;
    tick();
    clear_in(); ex_valid = 1; ex_B_type = 1; ex_pc = 32'h304; ex_pred_taken = 1; ex_pred_pc = 32'h344;
    tick();
    clear_in();
    for (int i = 0; i < 3; i++) tick();
    chk("t5_cnt", mispredict_cnt, 2);
    chk("t5_single_redirect", 32'(rd_seen - r0), 1);
    if_B_type = 1; if_pc = 32'h304; if_imme = 32'h40; #1;
    chk("t5_bht_kept", 32'(pred_taken), 1);
    tick();
    clear_in(); ex_valid = 1; ex_B_type = 1; ex_pc = 32'h100; ex_taken = 1; ex_target = 32'h180; ex_pred_taken = 1; ex_pred_pc = 32'h140;
    tick();
    clear_in(); #1;
    chk("t6_flush_before", 32'(flush), 1);
    rst = 1; #1;
    chk("t6_flush", 32'(flush), 0);
    chk("t6_redirect", 32'(redirect), 0);
    chk("t6_redirect_pc", redirect_pc, 0);
    chk("t6_cnt", mispredict_cnt, 0);
    if_B_type = 1; if_pc = 32'h100; if_imme = 32'h40; #1;
    chk("t6_bht_reset", 32'(pred_taken), 0);
    model_reset();
    cq.delete();
    rq.delete();
    clear_in();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 600; i++) begin
      rand_in();
      tick();
    end
    clear_in();
    for (int i = 0; i < FC + 3; i++) tick();
    chk("redirect_drain", 32'(rq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
